// File: rtl/prio_enc_q.sv
// prio_enc_q
// Registered priority encoder with request queueing. Request lines are
// collected into a sticky pending vector. The highest-priority pending bit is
// encoded and offered downstream through a single-entry valid/ready output
// slot. Simultaneous requests are drained one index per accepted transfer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_in     request lines, OR-ed into pending on every edge
//   clr_in     synchronous clear of pending, overflow and output slot
//   enc_ready  consumer accepts enc_idx while enc_valid is high
//   enc_idx    encoded index of the granted request
//   enc_valid  enc_idx / enc_more are valid
//   enc_more   other bits were still pending when enc_idx was loaded
//   pending    registered pending vector
//   ovf        sticky: a request arrived on a bit that was already pending
module prio_enc_q #(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_in,
  input  logic             clr_in,
  input  logic             enc_ready,
  output logic [IDX_W-1:0] enc_idx,
  output logic             enc_valid,
  output logic             enc_more,
  output logic [WIDTH-1:0] pending,
  output logic             ovf
);

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] enc_idx_q, enc_idx_d;
  logic             enc_valid_q, enc_valid_d;
  logic             enc_more_q, enc_more_d;
  logic             ovf_q, ovf_d;

  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_oh;
  logic             any_pending;
  logic             load;

  // Selection looks only at the registered pending vector, so there is no
  // path from req_in to the encoded index within a cycle.
  always_comb begin
    sel_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending_q[i]) sel_idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending_q[i]) sel_idx = IDX_W'(i);
      end
    end
  end

  assign sel_oh      = WIDTH'(1) << sel_idx;
  assign any_pending = |pending_q;
  assign load        = (!enc_valid_q || enc_ready) && any_pending;

  always_comb begin
    pending_d   = pending_q | req_in;
    enc_idx_d   = enc_idx_q;
    enc_valid_d = enc_valid_q;
    enc_more_d  = enc_more_q;
    // The bit being granted this cycle does not count as an overflow.
    ovf_d       = ovf_q | (|(req_in & pending_q & ~(load ? sel_oh : '0)));

    if (load) begin
      enc_idx_d   = sel_idx;
      enc_valid_d = 1'b1;
      enc_more_d  = |(pending_q & ~sel_oh);
      // A fresh request on the granted bit re-arms it.
      pending_d   = (pending_q & ~sel_oh) | req_in;
    end else if (enc_valid_q && enc_ready) begin
      enc_valid_d = 1'b0;
    end

    if (clr_in) begin
      pending_d   = '0;
      ovf_d       = 1'b0;
      enc_valid_d = 1'b0;
      enc_more_d  = 1'b0;
      enc_idx_d   = enc_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      enc_idx_q   <= '0;
      enc_valid_q <= 1'b0;
      enc_more_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      enc_idx_q   <= enc_idx_d;
      enc_valid_q <= enc_valid_d;
      enc_more_q  <= enc_more_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pending   = pending_q;
  assign enc_idx   = enc_idx_q;
  assign enc_valid = enc_valid_q;
  assign enc_more  = enc_more_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_prio_enc_q.sv
// Bench for prio_enc_q: one LSB-first and one MSB-first instance share the
// stimulus. Expected (index, more) pairs are queued per instance when the
// stimulus is driven and popped whenever an instance completes a transfer.
module tb_prio_enc_q;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic       clr_in;
  logic       enc_ready;

  logic [2:0] l_idx, m_idx;
  logic       l_valid, m_valid, l_more, m_more, l_ovf, m_ovf;
  logic [7:0] l_pend, m_pend;

  int n_vec = 0;
  int n_err = 0;

  // Expected transfers, encoded as idx*2 + more.
  int q_l[$];
  int q_m[$];

  prio_enc_q #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr_in(clr_in),
    .enc_ready(enc_ready), .enc_idx(l_idx), .enc_valid(l_valid),
    .enc_more(l_more), .pending(l_pend), .ovf(l_ovf)
  );

  prio_enc_q #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr_in(clr_in),
    .enc_ready(enc_ready), .enc_idx(m_idx), .enc_valid(m_valid),
    .enc_more(m_more), .pending(m_pend), .ovf(m_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A transfer completes at the next rising edge when valid and ready are
  // both high and no clear is pending.
  always @(negedge clk) begin
    if (rst_n && enc_ready && !clr_in) begin
      if (l_valid) begin
        if (q_l.size() == 0) chk("lsb_unexpected", {29'd0, l_idx}, -1);
        else begin
          int e;
          e = q_l.pop_front();
          chk("lsb_idx", {29'd0, l_idx}, e / 2);
          chk("lsb_more", {31'd0, l_more}, e % 2);
        end
      end
      if (m_valid) begin
        if (q_m.size() == 0) chk("msb_unexpected", {29'd0, m_idx}, -1);
        else begin
          int e;
          e = q_m.pop_front();
          chk("msb_idx", {29'd0, m_idx}, e / 2);
          chk("msb_more", {31'd0, m_more}, e % 2);
        end
      end
    end
  end

  int drain_l[3] = '{2, 5, 7};
  int drain_m[3] = '{7, 5, 2};

  initial begin
    rst_n     = 1'b0;
    req_in    = 8'hFF;
    clr_in    = 1'b0;
    enc_ready = 1'b0;

    // Reset held with all requests asserted.
    repeat (3) tick();
    chk("rst_valid", {31'd0, l_valid}, 0);
    chk("rst_idx",   {29'd0, l_idx}, 0);
    chk("rst_more",  {31'd0, l_more}, 0);
    chk("rst_pend",  {24'd0, l_pend}, 0);
    chk("rst_ovf",   {31'd0, l_ovf}, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 0);

    rst_n = 1'b1;
    tick();
    chk("rel1_valid", {31'd0, l_valid}, 0);
    chk("rel1_pend",  {24'd0, l_pend}, 8'hFF);
    tick();
    chk("rel2_valid", {31'd0, l_valid}, 1);
    chk("rel2_idx",   {29'd0, l_idx}, 0);
    chk("rel2_more",  {31'd0, l_more}, 1);
    chk("rel2_m_idx", {29'd0, m_idx}, 7);
    req_in = 8'h00;
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    chk("clr0_pend",  {24'd0, l_pend}, 0);
    chk("clr0_valid", {31'd0, l_valid}, 0);
    chk("clr0_ovf",   {31'd0, l_ovf}, 0);

    // Priority drain, single-cycle request.
    q_l.push_back(2 * 2 + 1); q_l.push_back(5 * 2 + 1); q_l.push_back(7 * 2 + 0);
    q_m.push_back(7 * 2 + 1); q_m.push_back(5 * 2 + 1); q_m.push_back(2 * 2 + 0);
    enc_ready = 1'b1;
    req_in    = 8'b1010_0100;
    tick();
    req_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_l_idx", {29'd0, l_idx}, drain_l[i]);
      chk("drain_m_idx", {29'd0, m_idx}, drain_m[i]);
      chk("drain_valid", {31'd0, l_valid}, 1);
    end
    tick();
    chk("drain_end_valid", {31'd0, l_valid}, 0);
    chk("drain_end_pend",  {24'd0, l_pend}, 0);
    chk("drain_end_m_valid", {31'd0, m_valid}, 0);
    tick();

    // Backpressure and overflow.
    enc_ready = 1'b0;
    req_in    = 8'h01;
    tick();
    req_in = 8'h08;
    tick();
    chk("bp_idx0",  {29'd0, l_idx}, 0);
    chk("bp_ovf0",  {31'd0, l_ovf}, 0);
    chk("bp_more0", {31'd0, l_more}, 0);
    tick();
    req_in = 8'h00;
    chk("bp_ovf1",  {31'd0, l_ovf}, 1);
    chk("bp_pend",  {24'd0, l_pend}, 8'h08);
    chk("bp_m_ovf", {31'd0, m_ovf}, 1);
    tick();
    tick();
    chk("bp_hold_idx",   {29'd0, l_idx}, 0);
    chk("bp_hold_valid", {31'd0, l_valid}, 1);
    q_l.push_back(0 * 2 + 0); q_l.push_back(3 * 2 + 0);
    q_m.push_back(0 * 2 + 0); q_m.push_back(3 * 2 + 0);
    enc_ready = 1'b1;
    tick();
    chk("bp_next_idx", {29'd0, l_idx}, 3);
    tick();
    chk("bp_end_valid", {31'd0, l_valid}, 0);
    chk("bp_ovf_sticky", {31'd0, l_ovf}, 1);
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    chk("bp_clr_ovf", {31'd0, l_ovf}, 0);

    // Re-arm race on bit 4.
    q_l.push_back(4 * 2 + 0); q_l.push_back(4 * 2 + 0);
    q_m.push_back(4 * 2 + 0); q_m.push_back(4 * 2 + 0);
    req_in = 8'h10;
    tick();
    tick();
    req_in = 8'h00;
    chk("rearm_pend", {24'd0, l_pend}, 8'h10);
    chk("rearm_ovf",  {31'd0, l_ovf}, 0);
    chk("rearm_idx",  {29'd0, l_idx}, 4);
    tick();
    chk("rearm_idx2",  {29'd0, l_idx}, 4);
    chk("rearm_pend2", {24'd0, l_pend}, 0);
    tick();
    chk("rearm_end_valid", {31'd0, l_valid}, 0);

    // Clear with a simultaneous request.
    enc_ready = 1'b0;
    req_in    = 8'hF0;
    tick();
    tick();
    chk("clr_pre_pend",  {24'd0, l_pend}, 8'hF0);
    chk("clr_pre_valid", {31'd0, l_valid}, 1);
    chk("clr_pre_ovf",   {31'd0, l_ovf}, 1);
    req_in    = 8'h01;
    clr_in    = 1'b1;
    enc_ready = 1'b1;
    tick();
    clr_in = 1'b0;
    req_in = 8'h00;
    chk("clr_pend",  {24'd0, l_pend}, 0);
    chk("clr_valid", {31'd0, l_valid}, 0);
    chk("clr_ovf",   {31'd0, l_ovf}, 0);
    chk("clr_more",  {31'd0, l_more}, 0);
    chk("clr_m_valid", {31'd0, m_valid}, 0);
    repeat (3) tick();
    chk("clr_no_emit", {31'd0, l_valid}, 0);

    chk("lsb_queue_left", q_l.size(), 0);
    chk("msb_queue_left", q_m.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
